// File: rtl/pipeline_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO for the late-ALU path.
// States: IDLE accept | MUL product pipeline | DIV restoring iterations | FIXUP sign fix or div-by-zero
module pipeline_muldiv #(
  parameter int XLEN               = 32,
  parameter int MUL_LATENCY        = 2,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic            illegal
);
  localparam int N  = XLEN / DIV_BITS_PER_CYCLE;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(N - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_ma, r_mb;
  logic [XLEN-1:0]     r_rem, r_quo, r_dvs;
  logic                r_qneg, r_rneg, r_dz;
  logic [XLEN-1:0]     r_hi, r_lo;
  logic                r_done, r_dz_pulse, r_illegal;

  logic [2*XLEN-1:0]   w_prod, w_mul_res;
  logic                w_msgn, w_sdiv, w_neg_a, w_neg_b, w_bzero;
  logic [XLEN-1:0]     w_abs_a, w_abs_b;
  logic [XLEN-1:0]     w_rem_nx, w_quo_nx;
  logic [XLEN:0]       w_shift, w_trial;

  assign w_msgn  = (req_op == 3'b000);
  assign w_sdiv  = (req_op == 3'b010);
  assign w_neg_a = w_sdiv & req_a[XLEN-1];
  assign w_neg_b = w_sdiv & req_b[XLEN-1];
  assign w_abs_a = w_neg_a ? -req_a : req_a;
  assign w_abs_b = w_neg_b ? -req_b : req_b;
  assign w_bzero = (req_b == '0);

  assign w_prod = r_ma * r_mb;

  // Operands stay latched during MUL, so the pipe only has to carry the product forward.
  if (MUL_LATENCY == 1) begin : g_mul_direct
    assign w_mul_res = w_prod;
  end else begin : g_mul_pipe
    logic [2*XLEN-1:0] r_mpipe [MUL_LATENCY-1];
    always_ff @(posedge clk) begin
      r_mpipe[0] <= w_prod;
      for (int i = 1; i < MUL_LATENCY - 1; i++) r_mpipe[i] <= r_mpipe[i-1];
    end
    assign w_mul_res = r_mpipe[MUL_LATENCY-2];
  end

  // Remainder stays below the divisor, so bit XLEN of the trial difference is the borrow.
  always_comb begin
    w_rem_nx = r_rem;
    w_quo_nx = r_quo;
    w_shift  = '0;
    w_trial  = '0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      w_shift  = {w_rem_nx, w_quo_nx[XLEN-1]};
      w_trial  = w_shift - {1'b0, r_dvs};
      w_quo_nx = {w_quo_nx[XLEN-2:0], ~w_trial[XLEN]};
      w_rem_nx = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
      r_illegal  <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (req_valid) begin
            case (req_op)
              3'b000, 3'b001: begin
                r_ma    <= {{XLEN{w_msgn & req_a[XLEN-1]}}, req_a};
                r_mb    <= {{XLEN{w_msgn & req_b[XLEN-1]}}, req_b};
                r_cnt   <= MUL_LAST;
                r_state <= S_MUL;
              end
              3'b010, 3'b011: begin
                r_qneg  <= w_neg_a ^ w_neg_b;
                r_rneg  <= w_neg_a;
                r_dz    <= w_bzero;
                r_quo   <= w_bzero ? req_a : w_abs_a;
                r_rem   <= '0;
                r_dvs   <= w_abs_b;
                r_cnt   <= DIV_LAST;
                r_state <= w_bzero ? S_FIXUP : S_DIV;
              end
              3'b100: begin
                r_hi   <= req_a;
                r_done <= 1'b1;
              end
              3'b101: begin
                r_lo   <= req_a;
                r_done <= 1'b1;
              end
              default: r_illegal <= 1'b1;
            endcase
          end
          S_MUL: begin
            if (r_cnt == '0) begin
              {r_hi, r_lo} <= w_mul_res;
              r_done       <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          S_DIV: begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            if (r_cnt == '0) r_state <= S_FIXUP;
            else             r_cnt   <= r_cnt - CW'(1);
          end
          S_FIXUP: begin
            if (r_dz) begin
              r_lo       <= '1;
              r_hi       <= r_quo;
              r_dz_pulse <= 1'b1;
            end else begin
              r_lo <= r_qneg ? -r_quo : r_quo;
              r_hi <= r_rneg ? -r_rem : r_rem;
            end
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign req_ready   = ~busy;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign done        = r_done;
  assign div_by_zero = r_dz_pulse;
  assign illegal     = r_illegal;
endmodule

// File: tb/tb_pipeline_muldiv.sv
// Directed bench for pipeline_muldiv: default instance plus a radix-16 / single-stage-multiply instance.
module tb_pipeline_muldiv;
  logic        clk = 1'b0;
  logic        rst, req_valid, flush, sel4;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;

  logic        rdy0, busy0, done0, dz0, ill0, rdy4, busy4, done4, dz4, ill4;
  logic [31:0] hi0, lo0, hi4, lo4;
  logic        o_ready, o_busy, o_done, o_dz, o_ill;
  logic [31:0] o_hi, o_lo;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_muldiv #(.XLEN(32), .MUL_LATENCY(2), .DIV_BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel4), .req_ready(rdy0),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .hi(hi0), .lo(lo0), .busy(busy0), .done(done0), .div_by_zero(dz0), .illegal(ill0));

  pipeline_muldiv #(.XLEN(32), .MUL_LATENCY(1), .DIV_BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel4), .req_ready(rdy4),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .hi(hi4), .lo(lo4), .busy(busy4), .done(done4), .div_by_zero(dz4), .illegal(ill4));

  assign o_ready = sel4 ? rdy4  : rdy0;
  assign o_busy  = sel4 ? busy4 : busy0;
  assign o_done  = sel4 ? done4 : done0;
  assign o_dz    = sel4 ? dz4   : dz0;
  assign o_ill   = sel4 ? ill4  : ill0;
  assign o_hi    = sel4 ? hi4   : hi0;
  assign o_lo    = sel4 ? lo4   : lo0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint p;
    int     sa, sbv;
    sa = a; sbv = b; edz = 1'b0; eh = '0; el = '0; p = 0;
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sbv); {eh, el} = p; end
      3'd1: begin p = longint'({32'b0, a}) * longint'({32'b0, b}); {eh, el} = p; end
      default: begin
        if (b == 0) begin
          el = '1; eh = a; edz = 1'b1;
        end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000; eh = '0;
        end else if (op == 3'd2) begin
          el = sa / sbv; eh = sa % sbv;
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output int bcyc);
    cyc = 0; bcyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (o_busy) bcyc++;
      if (o_done) break;
    end
  endtask

  // Latency counts negedges after the accept edge up to and including the done cycle.
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int l, input int n);
    exp_t e;
    logic [31:0] eh, el;
    logic edz;
    int cyc, bcyc;
    model(op, a, b, eh, el, edz);
    e.tag = tag; e.hi = eh; e.lo = el; e.dz = edz;
    e.cyc = (op < 3'd2) ? l + 1 : ((b == 0) ? 2 : n + 2);
    sb.push_back(e);
    issue(op, a, b);
    wait_done(100, cyc, bcyc);
    e = sb.pop_front();
    chk({e.tag, " done"}, o_done, 1);
    chk({e.tag, " latency"}, cyc, e.cyc);
    chk({e.tag, " busy cycles"}, bcyc, e.cyc - 1);
    chk({e.tag, " hi"}, o_hi, e.hi);
    chk({e.tag, " lo"}, o_lo, e.lo);
    chk({e.tag, " div_by_zero"}, o_dz, e.dz);
    chk({e.tag, " ready"}, o_ready, 1);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    issue(op, v, 32'h0);
    @(negedge clk);
    chk("mt done", o_done, 1);
  endtask

  initial begin
    int ndone;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; sel4 = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset hi", o_hi, 0);
    chk("reset lo", o_lo, 0);
    chk("reset busy", o_busy, 0);
    chk("reset done", o_done, 0);
    chk("reset ready", o_ready, 1);

    run("mult", 3'd0, 32'hFFFF_FFFF, 32'h2, 2, 32);
    run("multu", 3'd1, 32'hFFFF_FFFF, 32'h2, 2, 32);
    run("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'h2, 2, 32);
    run("divu 100/7", 3'd3, 32'd100, 32'd7, 2, 32);
    run("divu 5/0", 3'd3, 32'd5, 32'd0, 2, 32);
    run("div overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32);
    run("div pos/neg", 3'd2, 32'h0123_4567, 32'hFFFF_FFF3, 2, 32);
    run("div by zero signed", 3'd2, 32'hFFFF_FF00, 32'd0, 2, 32);
    for (int i = 0; i < 4; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      run("random", rop, ra, rb, 2, 32);
    end

    // mthi then mtlo issued back to back
    @(negedge clk);
    req_op = 3'd4; req_a = 32'h1234; req_valid = 1'b1;
    @(posedge clk); #1;
    req_op = 3'd5; req_a = 32'h5678;
    @(negedge clk);
    chk("mthi done", o_done, 1);
    chk("mthi busy", o_busy, 0);
    chk("mthi hi", o_hi, 32'h1234);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mtlo done", o_done, 1);
    chk("mtlo busy", o_busy, 0);
    chk("mtlo hi", o_hi, 32'h1234);
    chk("mtlo lo", o_lo, 32'h5678);
    @(negedge clk);
    chk("done single pulse", o_done, 0);

    issue(3'd7, 32'hDEAD, 32'hBEEF);
    @(negedge clk);
    chk("illegal pulse", o_ill, 1);
    chk("illegal no done", o_done, 0);
    chk("illegal hi", o_hi, 32'h1234);
    chk("illegal lo", o_lo, 32'h5678);
    @(negedge clk);
    chk("illegal single pulse", o_ill, 0);

    mt(3'd4, 32'hAAAA);
    mt(3'd5, 32'h5555);

    // flush at the tenth divide iteration
    issue(3'd3, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush div busy", o_busy, 0);
    chk("flush div done", o_done, 0);
    chk("flush div hi", o_hi, 32'hAAAA);
    chk("flush div lo", o_lo, 32'h5555);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    chk("flush div late done", ndone, 0);

    // flush coinciding with the multiply write edge
    issue(3'd0, 32'd3, 32'd4);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush mul busy", o_busy, 0);
    chk("flush mul done", o_done, 0);
    chk("flush mul hi", o_hi, 32'hAAAA);
    chk("flush mul lo", o_lo, 32'h5555);

    // flush drops a same-cycle request in IDLE
    req_op = 3'd4; req_a = 32'hDEAD; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush drop done", o_done, 0);
    chk("flush drop hi", o_hi, 32'hAAAA);

    issue(3'd2, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst mid-div hi", o_hi, 0);
    chk("rst mid-div lo", o_lo, 0);
    chk("rst mid-div busy", o_busy, 0);
    chk("rst mid-div done", o_done, 0);

    run("post-rst multu", 3'd1, 32'h0001_0000, 32'h0001_0000, 2, 32);

    sel4 = 1'b1;
    run("r16 divu 100/7", 3'd3, 32'd100, 32'd7, 1, 8);
    run("r16 div -7/2", 3'd2, 32'hFFFF_FFF9, 32'h2, 1, 8);
    run("l1 mult", 3'd0, 32'hFFFF_FFFF, 32'h2, 1, 8);
    run("r16 divu 5/0", 3'd3, 32'd5, 32'd0, 1, 8);
    sel4 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_muldiv.md
# pipeline_muldiv

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the late-ALU path of the MIPS pipeline. It accepts one operation at a time from the ALU stage and supports signed and unsigned multiply, divide, `mthi` and `mtlo`. It signals `busy` so that the issue logic stalls dependent `mfhi`/`mflo`. Multiply latency and divider radix are configurable.

## Interface
- XLEN, 32, operand/HI/LO width (≥8, even)
- MUL_LATENCY, 2, edges from accept to HI/LO write for mult/multu (1..4)
- DIV_BITS_PER_CYCLE, 1, quotient bits retired per divider iteration (1, 2 or 4; must divide XLEN)

- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  unit can accept (= !busy)
- req_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others illegal
- req_a  input  XLEN  rs operand (dividend / multiplicand / mthi-mtlo source)
- req_b  input  XLEN  rt operand (divisor / multiplier)
- flush  input  1  abort in-flight op, drop same-cycle request
- hi  output  XLEN  HI register
- lo  output  XLEN  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse in the cycle after HI/LO are written
- div_by_zero  output  1  pulses with done when a div/divu had req_b == 0
- illegal  output  1  one-cycle pulse after an illegal req_op is accepted; HI/LO unchanged

## Operation
- States: IDLE, MUL, DIV, FIXUP. busy = (state != IDLE). Accept = req_valid & req_ready & !flush.
- mthi/mtlo: from IDLE, write hi (or lo) = req_a at the accept edge; done pulses; state stays IDLE.
- mult/multu: latch the operands and enter MUL. A 2·XLEN product (sign- or zero-extended operands) passes through MUL_LATENCY register stages. At the final edge, hi = product[2XLEN-1:XLEN], lo = product[XLEN-1:0], and the state returns to IDLE.
- div/divu, b != 0: latch |a| and |b| (raw values for divu) and record the signs; enter DIV. Restoring division retires DIV_BITS_PER_CYCLE bits per edge for N = XLEN/DIV_BITS_PER_CYCLE edges, then FIXUP. On the FIXUP edge:
  - lo = quotient, negated if sign(a) != sign(b) (signed only).
  - hi = remainder, negated if a < 0 (signed only).
  - State returns to IDLE.
- Divide by zero: skip iteration. On the next edge, lo = all-ones, hi = req_a, div_by_zero = 1, done = 1; state returns to IDLE.
- Signed overflow (most-negative / −1): lo = most-negative, hi = 0. No flag is raised.
- flush in any non-IDLE state: the next edge returns to IDLE. HI/LO are unchanged and no done is raised.
- rst overrides everything: hi = 0, lo = 0, state IDLE, busy/done/div_by_zero/illegal = 0.
- While busy, hi/lo hold their previous values. Avoiding stale `mfhi`/`mflo` reads is the upstream stage's responsibility, using busy.

## Timing
- Accept at edge E0. HI/LO write occurs at edge:
  - mthi/mtlo: E0
  - mult: E_MUL_LATENCY
  - div: E_(N+1) (default 33)
  - div-by-zero: E1
- done/div_by_zero are registered and high for exactly the cycle following the write edge.
- req_ready is high in the cycle done is high, so back-to-back issue has zero bubbles.
- An mthi/mtlo accepted in IDLE never asserts busy.
- flush and a completing write edge in the same cycle: flush wins, HI/LO are not written, no done.
- All arithmetic is XLEN-bit wrap-around except the product, which is 2·XLEN bits.

## Test plan
- mult 0xFFFFFFFF×0x00000002 → hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE. done exactly MUL_LATENCY edges after accept.
- div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 → lo=14, hi=2. busy for 33 cycles, done in cycle 34. Repeat with DIV_BITS_PER_CYCLE=4 → done after 9 edges.
- divu 5/0 → lo=0xFFFFFFFF, hi=5, div_by_zero=1 and done=1 one edge after accept.
- div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, no flag.
- Start div with HI/LO = 0xAAAA/0x5555 and assert flush at iteration 10 → busy low next cycle, HI/LO unchanged, no done. Repeat with rst mid-div → HI/LO = 0.
- mthi 0x1234 followed next cycle by mtlo 0x5678 → two done pulses, hi=0x1234, lo=0x5678, busy never high. req_op=111 → illegal pulse, HI/LO unchanged.
